// File: rtl/mix_div30.sv
// Sequential sign-magnitude divider for MIX DIV: |rA|:|rX| / |V| -> q (rA), r (rX).
// Restoring, one quotient bit per cycle; define MIX_DIV_RADIX4_EN for two bits per cycle.
module mix_div30 #(
  parameter int unsigned WIDTH = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH:0]   x,
  input  logic [WIDTH:0]   v,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   q,
  output logic [WIDTH:0]   r,
  output logic             overflow
);

`ifdef MIX_DIV_RADIX4_EN
  localparam int unsigned Iters = WIDTH / 2;
`else
  localparam int unsigned Iters = WIDTH;
`endif
  localparam int unsigned CntW = $clog2(Iters + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(Iters - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } state_e;

  state_e           state_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] dv_q;
  logic [CntW-1:0]  cnt_q;
  logic             sa_q;
  logic             sv_q;

  // One restoring step: shift {rem, sh} left, trial-subtract dv, shift in the quotient bit.
  function automatic logic [2*WIDTH:0] div_step(input logic [WIDTH:0]   rem,
                                                input logic [WIDTH-1:0] sh,
                                                input logic [WIDTH-1:0] dv);
    logic [WIDTH+1:0] wide;
    logic             qb;
    wide = {rem, sh[WIDTH-1]};
    qb   = (wide >= {2'b00, dv});
    if (qb) begin
      wide = wide - {2'b00, dv};
    end
    div_step = {wide[WIDTH:0], sh[WIDTH-2:0], qb};
  endfunction

  logic [2*WIDTH:0] step1;
  logic [2*WIDTH:0] step_res;
  logic [WIDTH:0]   rem_n;
  logic [WIDTH-1:0] shreg_n;

  always_comb begin
    step1 = div_step(rem_q, shreg_q, dv_q);
`ifdef MIX_DIV_RADIX4_EN
    step_res = div_step(step1[2*WIDTH:WIDTH], step1[WIDTH-1:0], dv_q);
`else
    step_res = step1;
`endif
    rem_n   = step_res[2*WIDTH:WIDTH];
    shreg_n = step_res[WIDTH-1:0];
  end

  logic ovf_start;
  assign ovf_start = (a[WIDTH-1:0] >= v[WIDTH-1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      q        <= '0;
      r        <= '0;
      rem_q    <= '0;
      shreg_q  <= '0;
      dv_q     <= '0;
      cnt_q    <= '0;
      sa_q     <= 1'b0;
      sv_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            sa_q <= a[WIDTH];
            sv_q <= v[WIDTH];
            dv_q <= v[WIDTH-1:0];
            if (ovf_start) begin
              // Quotient would not fit: hand back the operands untouched.
              state_q  <= StFin;
              busy     <= 1'b0;
              done     <= 1'b1;
              overflow <= 1'b1;
              q        <= a;
              r        <= x;
            end else begin
              state_q <= StRun;
              busy    <= 1'b1;
              rem_q   <= {1'b0, a[WIDTH-1:0]};
              shreg_q <= x[WIDTH-1:0];
              cnt_q   <= '0;
            end
          end
        end
        StRun: begin
          rem_q   <= rem_n;
          shreg_q <= shreg_n;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_q  <= StFin;
            busy     <= 1'b0;
            done     <= 1'b1;
            overflow <= 1'b0;
            q        <= {sa_q ^ sv_q, shreg_n};
            r        <= {sa_q, rem_n[WIDTH-1:0]};
          end
        end
        StFin: begin
          state_q <= StIdle;
          done    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_div30.sv
// Randomized self-checking bench for mix_div30 against an arithmetic reference model.
module tb_mix_div30;
  localparam int unsigned W = 30;
`ifdef MIX_DIV_RADIX4_EN
  localparam int NormLat = W / 2 + 1;
`else
  localparam int NormLat = W + 1;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W:0]   a = '0;
  logic [W:0]   x = '0;
  logic [W:0]   v = '0;
  logic         busy;
  logic         done;
  logic [W:0]   q;
  logic [W:0]   r;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  localparam logic [W-1:0] MaxMag = {W{1'b1}};

  mix_div30 #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .x        (x),
    .v        (v),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 2W-bit integer division plus MIX sign rules.
  task automatic model(input logic [W:0] ma, input logic [W:0] mx, input logic [W:0] mv,
                       output logic [W:0] eq, output logic [W:0] er, output logic eo);
    logic [63:0] dvd;
    logic [63:0] dvs;
    logic [63:0] quo;
    logic [63:0] rmd;
    dvd = {4'b0, ma[W-1:0], mx[W-1:0]};
    dvs = {34'b0, mv[W-1:0]};
    if ({34'b0, ma[W-1:0]} >= dvs) begin
      eq = ma;
      er = mx;
      eo = 1'b1;
    end else begin
      quo = dvd / dvs;
      rmd = dvd % dvs;
      eq = {ma[W] ^ mv[W], quo[W-1:0]};
      er = {ma[W], rmd[W-1:0]};
      eo = 1'b0;
    end
  endtask

  // inject[0]: second start in cycle 10; inject[1]: start during the done cycle.
  task automatic do_div(input string tag, input logic [W:0] ta, input logic [W:0] tx,
                        input logic [W:0] tv, input int inject);
    logic [W:0] eq, er;
    logic       eo;
    int         cyc;
    int         lat;
    bit         got;
    model(ta, tx, tv, eq, er, eo);
    a = ta; x = tx; v = tv; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    got = 0;
    while (!got && cyc <= 40) begin
      if (done) begin
        got = 1;
      end else begin
        if (!busy) check({tag, ".busy"}, {63'b0, busy}, 64'd1);
        if (inject[0] && cyc == 10) begin
          a = {1'b0, 30'd1}; x = '0; v = {1'b0, 30'd1}; start = 1'b1;
        end else begin
          start = 1'b0;
        end
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    if (!got) begin
      check({tag, ".timeout"}, 64'd0, 64'd1);
    end else begin
      lat = eo ? 1 : NormLat;
      check({tag, ".lat"}, 64'(cyc), 64'(lat));
      check({tag, ".q"}, 64'(q), 64'(eq));
      check({tag, ".r"}, 64'(r), 64'(er));
      check({tag, ".ovf"}, {63'b0, overflow}, {63'b0, eo});
      if (!eo) check({tag, ".busyfin"}, {63'b0, busy}, 64'd0);
      if (inject[1]) begin
        a = {1'b0, 30'd5}; x = '0; v = {1'b0, 30'd5}; start = 1'b1;
      end
      tick();
      start = 1'b0;
      check({tag, ".donepulse"}, {63'b0, done}, 64'd0);
      check({tag, ".idle"}, {63'b0, busy}, 64'd0);
      tick();
      check({tag, ".noacc"}, {62'b0, busy, done}, 64'd0);
      check({tag, ".qhold"}, 64'(q), 64'(eq));
      check({tag, ".rhold"}, 64'(r), 64'(er));
    end
  endtask

  initial begin
    logic [W-1:0] mv, ma;
    reset = 1'b1;
    tick();
    tick();
    check("rst.busy", {63'b0, busy}, 64'd0);
    check("rst.done", {63'b0, done}, 64'd0);
    check("rst.ovf", {63'b0, overflow}, 64'd0);
    check("rst.q", 64'(q), 64'd0);
    check("rst.r", 64'(r), 64'd0);
    reset = 1'b0;
    tick();

    do_div("basic", {1'b0, 30'd0}, {1'b0, 30'd17}, {1'b0, 30'd3}, 0);
    do_div("sign", {1'b1, 30'd0}, {1'b1, 30'd100}, {1'b1, 30'd7}, 0);
    do_div("ovf_eq", {1'b0, 30'd5}, {1'b1, 30'd11}, {1'b0, 30'd5}, 0);
    do_div("ovf_z", {1'b0, 30'd0}, {1'b0, 30'd9}, {1'b0, 30'd0}, 0);
    do_div("ovf_mz", {1'b0, 30'd0}, {1'b0, 30'd9}, {1'b1, 30'd0}, 0);
    do_div("max", {1'b0, MaxMag - 30'd1}, {1'b0, MaxMag}, {1'b0, MaxMag}, 0);
    do_div("busystart", {1'b1, 30'd12345}, {1'b0, 30'd999}, {1'b0, 30'd777777}, 1);
    do_div("finstart", {1'b0, 30'd3}, {1'b0, 30'd4242}, {1'b1, 30'd65537}, 2);

    // Reset during cycle 12 of a run aborts it with no done pulse.
    a = {1'b0, 30'd1}; x = {1'b0, 30'd5}; v = {1'b0, 30'd1000}; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 12; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort.busy", {63'b0, busy}, 64'd0);
    check("abort.q", 64'(q), 64'd0);
    check("abort.r", 64'(r), 64'd0);
    check("abort.ovf", {63'b0, overflow}, 64'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (done || busy) seen++;
        tick();
      end
      check("abort.nodone", 64'(seen), 64'd0);
    end
    do_div("after_rst", {1'b0, 30'd0}, {1'b0, 30'd17}, {1'b0, 30'd3}, 0);

    for (int n = 0; n < 24; n++) begin
      mv = W'($urandom) & MaxMag;
      if (n % 6 == 5) begin
        ma = mv + W'($urandom_range(0, 3));
      end else if (mv == 0) begin
        ma = '0;
      end else begin
        ma = W'($urandom) % mv;
      end
      do_div("rand", {1'($urandom), ma}, {1'($urandom), W'($urandom)}, {1'($urandom), mv}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
